// File: rtl/ball_motion_if.sv
// Signal bundle between the ball-motion block and its game-side neighbours.
// Strobe semantics: frame_tick and launch are single-cycle pulses that are acted on
// only in the cycle they are high; there is no back-pressure. wall_hit and paddle_hit
// are levels that matter only in a frame_tick cycle. ball_lost is a registered
// one-cycle pulse.
interface ball_motion_if;
    logic       frame_tick;
    logic       launch;
    logic [1:0] wall_hit;
    logic       paddle_hit;
    logic [8:0] ball_x;
    logic [7:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       in_play;
    logic       ball_lost;
    logic [1:0] state_dbg;

    modport master (
        output frame_tick, launch, wall_hit, paddle_hit,
        input  ball_x, ball_y, dir_x, dir_y, in_play, ball_lost, state_dbg
    );

    modport slave (
        input  frame_tick, launch, wall_hit, paddle_hit,
        output ball_x, ball_y, dir_x, dir_y, in_play, ball_lost, state_dbg
    );
endinterface

// File: rtl/ball_motion.sv
// Ball position/direction owner: launch, per-frame reflect-then-step, loss detection
// and timed respawn. All outputs come straight from registers.
module ball_motion #(
    parameter logic [8:0] X_START     = 9'd160,
    parameter logic [7:0] Y_START     = 8'd120,
    parameter logic [8:0] SPEED_X     = 9'd1,
    parameter logic [7:0] SPEED_Y     = 8'd1,
    parameter logic [8:0] X_MIN       = 9'd8,
    parameter logic [8:0] X_MAX       = 9'd312,
    parameter logic [7:0] Y_MIN       = 8'd8,
    parameter logic [7:0] Y_BOTTOM    = 8'd232,
    parameter logic [7:0] LOST_FRAMES = 8'd60
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic       in_play_q, in_play_d;
    logic       lost_q, lost_d;
    logic [7:0] cnt_q, cnt_d;

    logic       dx_ref, dy_ref;
    logic [9:0] x_wide;
    logic [8:0] x_step;
    logic [8:0] y_wide;
    logic [7:0] y_step;
    logic       y_lost;
    logic [7:0] cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= X_START;
            y_q       <= Y_START;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b0;
            in_play_q <= 1'b0;
            lost_q    <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            in_play_q <= in_play_d;
            lost_q    <= lost_d;
            cnt_q     <= cnt_d;
        end
    end

    // Reflection sets directions absolutely, so a hit held over several frames is harmless.
    // Steps are computed one bit wider than the position so nothing wraps before clamping.
    always_comb begin
        dx_ref = dir_x_q;
        dy_ref = dir_y_q;
        case (bus.wall_hit)
            2'd1:    dx_ref = 1'b1;
            2'd2:    dy_ref = 1'b1;
            2'd3:    dx_ref = 1'b0;
            default: ;
        endcase
        if (bus.paddle_hit && dir_y_q)
            dy_ref = 1'b0;

        if (dx_ref)
            x_wide = {1'b0, x_q} + {1'b0, SPEED_X};
        else if (x_q >= SPEED_X)
            x_wide = {1'b0, x_q - SPEED_X};
        else
            x_wide = 10'd0;

        if (x_wide < {1'b0, X_MIN})
            x_step = X_MIN;
        else if (x_wide > {1'b0, X_MAX})
            x_step = X_MAX;
        else
            x_step = x_wide[8:0];

        if (dy_ref)
            y_wide = {1'b0, y_q} + {1'b0, SPEED_Y};
        else if (y_q >= SPEED_Y)
            y_wide = {1'b0, y_q - SPEED_Y};
        else
            y_wide = 9'd0;

        y_lost = dy_ref && (y_wide >= {1'b0, Y_BOTTOM});
        if (y_lost)
            y_step = Y_BOTTOM;
        else if (y_wide < {1'b0, Y_MIN})
            y_step = Y_MIN;
        else
            y_step = y_wide[7:0];

        cnt_inc = cnt_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        lost_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.launch) begin
                    state_d = ST_MOVE;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end
            end
            ST_MOVE: begin
                if (bus.frame_tick) begin
                    dir_x_d = dx_ref;
                    dir_y_d = dy_ref;
                    x_d     = x_step;
                    y_d     = y_step;
                    if (y_lost) begin
                        state_d = ST_LOST;
                        lost_d  = 1'b1;
                    end
                end
            end
            ST_LOST: begin
                if (bus.frame_tick) begin
                    if (cnt_inc == LOST_FRAMES) begin
                        cnt_d   = 8'd0;
                        x_d     = X_START;
                        y_d     = Y_START;
                        dir_x_d = 1'b1;
                        dir_y_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_play_d = (state_d == ST_MOVE);
    end

    always_comb begin
        bus.ball_x    = x_q;
        bus.ball_y    = y_q;
        bus.dir_x     = dir_x_q;
        bus.dir_y     = dir_y_q;
        bus.in_play   = in_play_q;
        bus.ball_lost = lost_q;
        bus.state_dbg = state_q;
    end

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed walk through launch, reflections, loss/respawn and
// async reset, followed by randomized frames checked against a behavioural model.
module tb_ball_motion;

    localparam int X_START = 160, Y_START = 120, X_MIN = 8, X_MAX = 312;
    localparam int Y_MIN = 8, Y_BOTTOM = 232, LOST_FRAMES = 60;
    localparam int S_IDLE = 0, S_MOVE = 1, S_LOST = 2;

    logic clk = 1'b0;
    logic reset;
    ball_motion_if bus();

    ball_motion dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [22:0] exp_q[$];

    int m_x, m_y, m_dx, m_dy, m_state, m_cnt, m_lost;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // behavioural reference
    function automatic void push_exp();
        int ip;
        ip = (m_state == S_MOVE) ? 1 : 0;
        exp_q.push_back({m_x[8:0], m_y[7:0], m_dx[0], m_dy[0], ip[0], m_lost[0], m_state[1:0]});
    endfunction

    function automatic void model_reset();
        m_x = X_START; m_y = Y_START; m_dx = 1; m_dy = 0;
        m_state = S_IDLE; m_cnt = 0; m_lost = 0;
    endfunction

    function automatic void model_clock(input bit l, input bit t, input int w, input bit p);
        int ndx, ndy, nx, ny;
        m_lost = 0;
        if (m_state == S_IDLE) begin
            if (l) begin
                m_state = S_MOVE; m_dx = 1; m_dy = 0;
            end
        end else if (m_state == S_MOVE) begin
            if (t) begin
                ndx = m_dx; ndy = m_dy;
                if (w == 1) ndx = 1;
                if (w == 3) ndx = 0;
                if (w == 2) ndy = 1;
                if (p && m_dy == 1) ndy = 0;
                nx = (ndx == 1) ? m_x + 1 : m_x - 1;
                if (nx < X_MIN) nx = X_MIN;
                if (nx > X_MAX) nx = X_MAX;
                ny = (ndy == 1) ? m_y + 1 : m_y - 1;
                if (ny < Y_MIN) ny = Y_MIN;
                m_dx = ndx; m_dy = ndy; m_x = nx;
                if (ndy == 1 && ny >= Y_BOTTOM) begin
                    m_y = Y_BOTTOM; m_state = S_LOST; m_lost = 1;
                end else begin
                    m_y = ny;
                end
            end
        end else begin
            if (t) begin
                m_cnt++;
                if (m_cnt == LOST_FRAMES) begin
                    m_cnt = 0; m_x = X_START; m_y = Y_START;
                    m_dx = 1; m_dy = 0; m_state = S_IDLE;
                end
            end
        end
        push_exp();
    endfunction

    // scoreboard
    task automatic compare();
        logic [22:0] e;
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check_val("ball_x",    int'(bus.ball_x),    int'(e[22:14]));
        check_val("ball_y",    int'(bus.ball_y),    int'(e[13:6]));
        check_val("dir_x",     int'(bus.dir_x),     int'(e[5]));
        check_val("dir_y",     int'(bus.dir_y),     int'(e[4]));
        check_val("in_play",   int'(bus.in_play),   int'(e[3]));
        check_val("ball_lost", int'(bus.ball_lost), int'(e[2]));
        check_val("state",     int'(bus.state_dbg), int'(e[1:0]));
    endtask

    // driver tasks
    task automatic cycle(input bit l, input bit t, input int w, input bit p);
        @(negedge clk);
        bus.launch     = l;
        bus.frame_tick = t;
        bus.wall_hit   = w[1:0];
        bus.paddle_hit = p;
        @(posedge clk);
        model_clock(l, t, w, p);
        #1;
        compare();
        bus.launch = 1'b0; bus.frame_tick = 1'b0; bus.wall_hit = 2'd0; bus.paddle_hit = 1'b0;
    endtask

    task automatic tick(input int w, input bit p, input bit l);
        cycle(l, 1'b1, w, p);
        cycle(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int dx, input int dy);
        check_val({tag, "_x"},  int'(bus.ball_x), x);
        check_val({tag, "_y"},  int'(bus.ball_y), y);
        check_val({tag, "_dx"}, int'(bus.dir_x),  dx);
        check_val({tag, "_dy"}, int'(bus.dir_y),  dy);
    endtask

    initial begin
        reset = 1'b1;
        bus.launch = 1'b0; bus.frame_tick = 1'b0; bus.wall_hit = 2'd0; bus.paddle_hit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_pos("rst", X_START, Y_START, 1, 0);
        check_val("rst_in_play", int'(bus.in_play), 0);
        check_val("rst_lost", int'(bus.ball_lost), 0);
        check_val("rst_state", int'(bus.state_dbg), S_IDLE);
        @(negedge clk);
        reset = 1'b0;

        // launch together with a tick only enters MOVE
        cycle(1'b1, 1'b1, 0, 1'b0);
        check_val("launch_in_play", int'(bus.in_play), 1);
        check_pos("launch", 160, 120, 1, 0);
        repeat (5) tick(0, 1'b0, 1'b0);
        check_pos("five", 165, 115, 1, 0);
        check_val("five_in_play", int'(bus.in_play), 1);

        // steer to (310,50) moving up-right
        repeat (40) tick(2, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0);
        repeat (104) tick(0, 1'b0, 1'b0);
        check_pos("pre_right", 310, 50, 1, 0);
        tick(3, 1'b0, 1'b0);
        check_pos("right1", 309, 49, 0, 0);
        tick(3, 1'b0, 1'b0);
        check_pos("right2", 308, 48, 0, 0);

        // steer to (9,9) moving up-left
        repeat (130) tick(2, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0);
        repeat (168) tick(0, 1'b0, 1'b0);
        check_pos("pre_left", 9, 9, 0, 0);
        tick(1, 1'b0, 1'b0);
        check_pos("left", 10, 8, 1, 0);
        tick(2, 1'b0, 1'b0);
        check_pos("top", 11, 9, 1, 1);

        // paddle plus right wall in one tick
        repeat (191) tick(0, 1'b0, 1'b0);
        check_pos("pre_pad", 202, 200, 1, 1);
        tick(3, 1'b1, 1'b0);
        check_pos("pad_wall", 201, 199, 0, 0);
        tick(0, 1'b1, 1'b0);
        check_pos("pad_up", 200, 198, 0, 0);

        // loss and respawn
        tick(2, 1'b0, 1'b0);
        repeat (32) tick(0, 1'b0, 1'b0);
        check_pos("pre_lost", 167, 231, 0, 1);
        cycle(1'b0, 1'b1, 0, 1'b0);
        check_val("lost_y", int'(bus.ball_y), 232);
        check_val("lost_pulse", int'(bus.ball_lost), 1);
        check_val("lost_in_play", int'(bus.in_play), 0);
        check_val("lost_state", int'(bus.state_dbg), S_LOST);
        cycle(1'b0, 1'b0, 0, 1'b0);
        check_val("lost_pulse_end", int'(bus.ball_lost), 0);
        repeat (59) tick(0, 1'b0, 1'b1);
        check_val("lost_59_state", int'(bus.state_dbg), S_LOST);
        check_val("lost_59_y", int'(bus.ball_y), 232);
        check_val("lost_59_in_play", int'(bus.in_play), 0);
        tick(0, 1'b0, 1'b0);
        check_val("respawn_state", int'(bus.state_dbg), S_IDLE);
        check_pos("respawn", 160, 120, 1, 0);

        // asynchronous reset mid-MOVE
        cycle(1'b1, 1'b0, 0, 1'b0);
        repeat (3) tick(2, 1'b0, 1'b0);
        check_pos("pre_arst", 163, 123, 1, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        push_exp();
        compare();
        check_pos("arst", 160, 120, 1, 0);
        check_val("arst_in_play", int'(bus.in_play), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick(1, 1'b0, 1'b0);
        check_pos("post_arst", 160, 120, 1, 0);
        check_val("post_arst_state", int'(bus.state_dbg), S_IDLE);

        // randomized frames against the model
        for (int i = 0; i < 3000; i++) begin
            int w;
            bit l, t, p;
            t = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 15) == 0);
            w = $urandom_range(0, 3);
            p = (w != 2) && ($urandom_range(0, 3) == 0);
            cycle(l, t, w, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
